// File: rtl/mem_responder.sv
// Serial memory responder: decodes 2-bit/cycle read and write requests, strobes a
// 16-bit memory port and serialises read replies. Define MEM_RESPONDER_WRITE_ACK_EN to add a write ACK.
module mem_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rx_pins,
    output logic [1:0]  tx_pins,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEM,
        REPLY_START,
        REPLY_DATA
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        , ACK
`endif
    } state_t;

    localparam logic [1:0] HDR_READ  = 2'b01;
    localparam logic [1:0] HDR_WRITE = 2'b10;

    state_t      state;
    state_t      next_state;
    logic [2:0]  cnt;
    logic        is_write;
    logic [15:0] reply;

    // Strobes and tx_pins decode straight from state, so a reset edge zeroes them
    // in the same cycle that IDLE is entered.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        next_state = state;
        tx_pins    = 2'b00;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_pins == HDR_READ || rx_pins == HDR_WRITE)
                    next_state = ADDR;
            end
            ADDR: begin
                if (cnt == 3'd7)
                    next_state = is_write ? WDATA : MEM;
            end
            WDATA: begin
                if (cnt == 3'd7)
                    next_state = MEM;
            end
            MEM: begin
                if (is_write) begin
                    mem_we = 1'b1;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
                    next_state = ACK;
`else
                    next_state = IDLE;
`endif
                end else begin
                    mem_re     = 1'b1;
                    next_state = REPLY_START;
                end
            end
            REPLY_START: begin
                tx_pins    = 2'b01;
                next_state = REPLY_DATA;
            end
            REPLY_DATA: begin
                tx_pins = reply[1:0];
                if (cnt == 3'd7)
                    next_state = IDLE;
            end
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            ACK: begin
                tx_pins    = 2'b10;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            is_write  <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            reply     <= 16'h0000;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (rx_pins == HDR_READ || rx_pins == HDR_WRITE)
                        is_write <= (rx_pins == HDR_WRITE);
                end
                // Pairs arrive LSB first, so shift in from the top; the 3-bit count wraps 7->0 on exit.
                ADDR: begin
                    mem_addr <= {rx_pins, mem_addr[15:2]};
                    cnt      <= cnt + 3'd1;
                end
                WDATA: begin
                    mem_wdata <= {rx_pins, mem_wdata[15:2]};
                    cnt       <= cnt + 3'd1;
                end
                REPLY_START: begin
                    reply <= mem_rdata;
                    cnt   <= 3'd0;
                end
                REPLY_DATA: begin
                    reply <= {2'b00, reply[15:2]};
                    cnt   <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and reset as in the rest of the CPU codebase.
REQ-002 SHALL have the following ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous active-high reset
- rx_pins  input  2  serial requests from the CPU TX side, 2 bits/cycle
- tx_pins  output  2  serial replies to the CPU RX side, 2 bits/cycle
- mem_addr  output  16  word address to the memory port
- mem_wdata  output  16  write data to the memory port
- mem_we  output  1  one-cycle write strobe
- mem_re  output  1  one-cycle read strobe
- mem_rdata  input  16  read data, valid the cycle after mem_re
- busy  output  1  high whenever the state is not IDLE

Function
REQ-003 SHALL implement the states IDLE, ADDR, WDATA, MEM, REPLY_START, REPLY_DATA and (config-dependent) ACK, with a 3-bit pair counter.
REQ-004 In IDLE, SHALL treat rx_pins as a header and decode it as follows:
- 00: stay IDLE.
- 01: read; go to ADDR.
- 10: write; go to ADDR.
- 11: reserved; ignore and stay IDLE.
REQ-005 With the header in cycle N, the ADDR state SHALL shift in 8 pairs (cycles N+1..N+8), least significant pair first, into mem_addr.
REQ-006 For a write, WDATA SHALL shift in 8 further pairs (N+9..N+16), LSB pair first, into mem_wdata; MEM in N+17 SHALL assert mem_we.
REQ-007 For a read, MEM in N+9 SHALL assert mem_re.
REQ-008 REPLY_START in N+10 SHALL drive tx_pins=01 and load mem_rdata into the reply shift register.
REQ-009 REPLY_DATA in N+11..N+18 SHALL drive the data LSB pair first, then return to IDLE.
REQ-010 mem_addr and mem_wdata SHALL be stable throughout the mem_we/mem_re cycle.
REQ-011 mem_we and mem_re SHALL never be high simultaneously, and each SHALL be high for exactly one cycle per request.
REQ-012 tx_pins SHALL be 00 in every state other than REPLY_START, REPLY_DATA and ACK.
REQ-013 rx_pins SHALL be ignored in MEM, REPLY_START, REPLY_DATA and ACK; there is no request queueing.
REQ-014 After a read, the earliest accepted next header is cycle N+19.
REQ-015 The pair counter SHALL wrap 7->0 exactly on the ADDR->next and WDATA->MEM transitions.
REQ-016 Address and data 0xFFFF SHALL need no special handling; the all-ones data pair 11 is legal inside payloads.

Reset
REQ-017 On a clock edge with reset high, the block SHALL enter IDLE and clear the counter, mem_addr, mem_wdata, the reply register, mem_we, mem_re, tx_pins and busy to 0.
REQ-018 A reset asserted mid-transaction SHALL abort it with no memory strobe; the first header SHALL be accepted on the first cycle reset is low.

Configuration
REQ-019 When macro MEM_RESPONDER_WRITE_ACK_EN is defined, the block SHALL follow a write MEM cycle (N+17) with ACK in N+18 driving tx_pins=10, then return to IDLE, so the earliest next header is N+19.
REQ-020 When MEM_RESPONDER_WRITE_ACK_EN is undefined, the block SHALL omit the ACK state, keep tx_pins at 00 for writes, and accept the earliest next header in N+18.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Read 0x1234 with the memory returning 0xBEEF: mem_re in N+9 with mem_addr=0x1234; tx_pins=01 at N+10, then pairs 3,3,2,3,2,3,3,2 over N+11..N+18.
- Write 0xA5C3 to 0x00FF: mem_we only in N+17 with mem_addr=0x00FF and mem_wdata=0xA5C3; tx_pins=10 at N+18 with the macro defined, 00 throughout without it.
- Header 11 in IDLE: busy stays 0 and no strobes occur; a header 01 the following cycle is accepted normally.
- Reset asserted at N+5 of a write: no mem_we, and all outputs 0 the next cycle; a read header right after reset is served correctly.
- Back-to-back read headers at N and N+19 with rx_pins held 01 in between: exactly two mem_re pulses, and header bits seen during the reply are ignored.
